// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signals of the shared BRAM port.
// The arbiter takes the slave view; requesters and the BRAM take the master view.
interface bram_port_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    output vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_wren, mem_addr, mem_data
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    input  vid_ack, vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_wren, mem_addr, mem_data
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the video fetch engine (priority) and the CPU bus,
// with a per-cycle grant, fixed 1-cycle read latency and bounded CPU starvation.
//
// state | meaning
// IDLE  | previous slot unused
// VID   | previous slot granted to video
// CPU   | previous slot granted to CPU
module bram_port_arbiter #(
  parameter int AW        = 13,
  parameter int DW        = 8,
  parameter int MAX_WAIT  = 4,
  parameter int VID_BURST = 8
) (
  input logic              clk_sys,
  input logic              reset,
  bram_port_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [7:0] BURST_MAX = 8'(VID_BURST);

  typedef enum logic [1:0] {ST_IDLE, ST_VID, ST_CPU} state_t;

  state_t        state, state_nxt;
  logic [3:0]    wait_cnt, wait_nxt;
  logic [7:0]    burst_cnt, burst_nxt;
  logic          grant_vid, grant_cpu, force_cpu;
  logic [AW-1:0] addr_q, addr_c;
  logic [DW-1:0] data_q, data_c;
  logic          vid_rvalid_q, cpu_rvalid_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      burst_cnt    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_nxt;
      burst_cnt    <= burst_nxt;
      addr_q       <= addr_c;
      data_q       <= data_c;
      vid_rvalid_q <= grant_vid;
      cpu_rvalid_q <= grant_cpu & ~bus.cpu_we;
    end
  end

  // Grants are combinational on the live requests; reset masks them so every output reads 0.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    force_cpu = 1'b0;
    state_nxt = ST_IDLE;
    wait_nxt  = '0;
    burst_nxt = '0;
    if (!reset) begin
      force_cpu = (state == ST_VID) && bus.cpu_req &&
                  ((wait_cnt == WAIT_MAX) || (burst_cnt == BURST_MAX));
      if (force_cpu)        grant_cpu = 1'b1;
      else if (bus.vid_req) grant_vid = 1'b1;
      else if (bus.cpu_req) grant_cpu = 1'b1;

      if (grant_vid) begin
        state_nxt = ST_VID;
        if (state != ST_VID)             burst_nxt = 8'd1;
        else if (burst_cnt >= BURST_MAX) burst_nxt = BURST_MAX;
        else                             burst_nxt = burst_cnt + 8'd1;
      end else if (grant_cpu) begin
        state_nxt = ST_CPU;
      end

      if (bus.cpu_req && !grant_cpu)
        wait_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + 4'd1;
    end
  end

  // Address/data hold their last value through idle slots.
  always_comb begin
    addr_c = addr_q;
    data_c = data_q;
    if (grant_vid) begin
      addr_c = bus.vid_addr;
    end else if (grant_cpu) begin
      addr_c = bus.cpu_addr;
      data_c = bus.cpu_wdata;
    end
  end

  assign bus.vid_ack    = grant_vid;
  assign bus.cpu_ack    = grant_cpu;
  assign bus.mem_wren   = grant_cpu & bus.cpu_we;
  assign bus.mem_addr   = addr_c;
  assign bus.mem_data   = data_c;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.vid_rdata  = bus.mem_q;
  assign bus.cpu_rdata  = bus.mem_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed and randomized checks of bram_port_arbiter against a registered BRAM model
// and a small shadow memory.
module tb_bram_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MW = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();
  bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

  bram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .VID_BURST(8)) u_dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus1));
  bram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(15), .VID_BURST(3)) u_dut2 (
    .clk_sys(clk_sys), .reset(reset), .bus(bus2));

  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (bus1.mem_wren) bram[bus1.mem_addr] <= bus1.mem_data;
    bus1.mem_q <= bram[bus1.mem_addr];
  end
  assign bus2.mem_q = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys); #1;
  endtask

  task automatic smp();
    @(negedge clk_sys);
  endtask

  task automatic set_vid(input logic req, input logic [AW-1:0] addr);
    bus1.vid_req  = req;
    bus1.vid_addr = addr;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data);
    bus1.cpu_req   = req;
    bus1.cpu_we    = we;
    bus1.cpu_addr  = addr;
    bus1.cpu_wdata = data;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_vack"},  32'(bus1.vid_ack),    32'd0);
    chk({tag, "_cack"},  32'(bus1.cpu_ack),    32'd0);
    chk({tag, "_vrv"},   32'(bus1.vid_rvalid), 32'd0);
    chk({tag, "_crv"},   32'(bus1.cpu_rvalid), 32'd0);
    chk({tag, "_wren"},  32'(bus1.mem_wren),   32'd0);
    chk({tag, "_addr"},  32'(bus1.mem_addr),   32'd0);
    chk({tag, "_data"},  32'(bus1.mem_data),   32'd0);
  endtask

  logic [DW-1:0] ref_mem [0:15];
  logic          vpend, cpend, exp_vrv, exp_crv;
  logic [DW-1:0] exp_vd, exp_cd;
  int            cwait;

  initial begin
    set_vid(1'b1, 13'h0042);
    set_cpu(1'b1, 1'b1, 13'h0077, 8'hEE);
    bus2.vid_req = 1'b0; bus2.vid_addr = '0;
    bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;

    // Power-on reset with both requests high: everything held at 0.
    smp();
    chk_quiet("por");
    cyc();
    set_vid(1'b0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    smp();
    chk("idle_vack", 32'(bus1.vid_ack), 32'd0);
    chk("idle_cack", 32'(bus1.cpu_ack), 32'd0);

    // CPU write then read.
    cyc();
    set_cpu(1'b1, 1'b1, 13'h0100, 8'h5A);
    smp();
    chk("wr_ack",  32'(bus1.cpu_ack),  32'd1);
    chk("wr_wren", 32'(bus1.mem_wren), 32'd1);
    chk("wr_addr", 32'(bus1.mem_addr), 32'h100);
    chk("wr_data", 32'(bus1.mem_data), 32'h5A);
    cyc();
    set_cpu(1'b1, 1'b0, 13'h0100, 8'h00);
    smp();
    chk("rd_ack",  32'(bus1.cpu_ack),    32'd1);
    chk("rd_wren", 32'(bus1.mem_wren),   32'd0);
    chk("wr_norv", 32'(bus1.cpu_rvalid), 32'd0);
    cyc();
    set_cpu(1'b0, 1'b0, 13'h0100, 8'h00);
    smp();
    chk("rd_rv",    32'(bus1.cpu_rvalid), 32'd1);
    chk("rd_data",  32'(bus1.cpu_rdata),  32'h5A);
    chk("rd_idle",  32'(bus1.cpu_ack),    32'd0);
    chk("rd_hold",  32'(bus1.mem_addr),   32'h100);

    // VID stream of 8 reads.
    for (int i = 0; i < 8; i++) bram[i] = 8'(8'h10 + i);
    for (int i = 0; i < 9; i++) begin
      cyc();
      set_vid(i < 8, 13'(i));
      smp();
      chk("vs_ack", 32'(bus1.vid_ack), (i < 8) ? 32'd1 : 32'd0);
      chk("vs_rv", 32'(bus1.vid_rvalid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("vs_data", 32'(bus1.vid_rdata), 32'h10 + 32'(i - 1));
    end

    // Contention: 4 VID grants, forced CPU on the 5th, then VID resumes.
    cyc();
    set_vid(1'b1, 13'h0004);
    set_cpu(1'b1, 1'b0, 13'h0100, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      smp();
      chk("ct_vack", 32'(bus1.vid_ack), (k < 5) ? 32'd1 : 32'd0);
      chk("ct_cack", 32'(bus1.cpu_ack), (k == 5) ? 32'd1 : 32'd0);
      cyc();
    end
    set_cpu(1'b0, 1'b0, '0, '0);
    smp();
    chk("ct_resume", 32'(bus1.vid_ack),    32'd1);
    chk("ct_crv",    32'(bus1.cpu_rvalid), 32'd1);
    chk("ct_cdata",  32'(bus1.cpu_rdata),  32'h5A);
    cyc();
    set_vid(1'b0, '0);
    smp();
    chk("ct_vrv", 32'(bus1.vid_rvalid), 32'd1);

    // Reset in the middle of a contended burst.
    cyc();
    set_vid(1'b1, 13'h0003);
    set_cpu(1'b1, 1'b1, 13'h0055, 8'hC3);
    smp();
    cyc();
    smp();
    chk("mr_pre_vack", 32'(bus1.vid_ack), 32'd1);
    reset = 1'b1;
    smp();
    chk_quiet("mr");
    cyc();
    reset = 1'b0;
    set_cpu(1'b1, 1'b0, 13'h0100, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      smp();
      chk("mr_vack", 32'(bus1.vid_ack), (k < 5) ? 32'd1 : 32'd0);
      chk("mr_cack", 32'(bus1.cpu_ack), (k == 5) ? 32'd1 : 32'd0);
      cyc();
    end
    set_vid(1'b0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);

    // Second instance: MAX_WAIT=15, VID_BURST=3 gives 3 VID, 1 CPU repeating.
    bus2.vid_req = 1'b1;
    bus2.cpu_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      smp();
      chk("b3_vack", 32'(bus2.vid_ack), (k % 4 != 3) ? 32'd1 : 32'd0);
      chk("b3_cack", 32'(bus2.cpu_ack), (k % 4 == 3) ? 32'd1 : 32'd0);
      cyc();
    end
    bus2.vid_req = 1'b0;
    bus2.cpu_req = 1'b0;

    // Random traffic over a 16-byte window against a shadow memory.
    cyc();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom_range(255, 0));
      bram[i]    = ref_mem[i];
    end
    vpend = 1'b0; cpend = 1'b0; exp_vrv = 1'b0; exp_crv = 1'b0;
    exp_vd = '0; exp_cd = '0; cwait = 0;
    for (int n = 0; n < 10000; n++) begin
      if (!vpend && ($urandom_range(1, 0) == 1)) begin
        vpend = 1'b1;
        bus1.vid_addr = 13'($urandom_range(15, 0));
      end
      bus1.vid_req = vpend;
      if (!cpend && ($urandom_range(2, 0) != 0)) begin
        cpend = 1'b1;
        set_cpu(1'b1, 1'($urandom_range(1, 0)), 13'($urandom_range(15, 0)),
                8'($urandom_range(255, 0)));
      end
      bus1.cpu_req = cpend;
      smp();
      chk("rn_vrv", 32'(bus1.vid_rvalid), 32'(exp_vrv));
      if (exp_vrv) chk("rn_vdata", 32'(bus1.vid_rdata), 32'(exp_vd));
      chk("rn_crv", 32'(bus1.cpu_rvalid), 32'(exp_crv));
      if (exp_crv) chk("rn_cdata", 32'(bus1.cpu_rdata), 32'(exp_cd));
      chk("rn_excl", 32'(bus1.vid_ack & bus1.cpu_ack), 32'd0);
      chk("rn_noidle", 32'((bus1.vid_req | bus1.cpu_req) & ~(bus1.vid_ack | bus1.cpu_ack)), 32'd0);
      chk("rn_wren", 32'(bus1.mem_wren), 32'(bus1.cpu_ack & bus1.cpu_we));
      exp_vrv = bus1.vid_ack;
      exp_crv = bus1.cpu_ack & ~bus1.cpu_we;
      if (bus1.vid_ack) begin
        chk("rn_vaddr", 32'(bus1.mem_addr), 32'(bus1.vid_addr));
        exp_vd = ref_mem[bus1.vid_addr[3:0]];
        vpend  = 1'b0;
      end
      if (bus1.cpu_ack) begin
        chk("rn_caddr", 32'(bus1.mem_addr), 32'(bus1.cpu_addr));
        chk("rn_cwait", 32'(cwait <= MW + 1), 32'd1);
        if (bus1.cpu_we) begin
          chk("rn_cwdata", 32'(bus1.mem_data), 32'(bus1.cpu_wdata));
          ref_mem[bus1.cpu_addr[3:0]] = bus1.cpu_wdata;
        end else begin
          exp_cd = ref_mem[bus1.cpu_addr[3:0]];
        end
        cwait = 0;
        cpend = 1'b0;
      end else if (bus1.cpu_req) begin
        cwait++;
      end
      cyc();
    end
    set_vid(1'b0, '0);
    set_cpu(1'b0, 1'b0, '0, '0);
    smp();
    chk("rn_tail_vrv", 32'(bus1.vid_rvalid), 32'(exp_vrv));
    chk("rn_tail_crv", 32'(bus1.cpu_rvalid), 32'(exp_crv));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
